// File: rtl/dbus_arbiter_pkg.sv
// Shared data-bus package: transaction type/size enums, request payload struct
// and its reset value. Imported by the bus interface, request buffer and arbiter.
package dbus_arbiter_pkg;

    localparam int unsigned ADDR_W = 32;
    localparam int unsigned DATA_W = 32;

    typedef enum logic {
        READ  = 1'b0,
        WRITE = 1'b1
    } ttype_e;

    typedef enum logic [1:0] {
        BYTE = 2'd0,
        HALF = 2'd1,
        WORD = 2'd2
    } tsize_e;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] wdata;
        ttype_e            ttype;
        tsize_e            tsize;
    } bus_req_t;

    localparam bus_req_t BUS_REQ_RST = '{addr: '0, wdata: '0, ttype: READ, tsize: WORD};

endpackage

// File: rtl/master_bus_if.sv
// System data bus handshake interface.
//   master modport: drives bstart/breq and request fields, receives bdone/rdata.
//   slave  modport: receives the request, drives bdone/rdata.
interface master_bus_if;
    import dbus_arbiter_pkg::*;

    logic              bstart;
    logic              breq;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    ttype_e            ttype;
    tsize_e            tsize;
    logic              bdone;
    logic [DATA_W-1:0] rdata;

    modport master (output bstart, breq, addr, wdata, ttype, tsize,
                    input  bdone, rdata);
    modport slave  (input  bstart, breq, addr, wdata, ttype, tsize,
                    output bdone, rdata);
endinterface

// File: rtl/dbus_req_buffer.sv
// One-entry request capture register for a master that could not be forwarded.
//   clk, rst : clock, async active-high reset
//   load     : capture d and set pend
//   clear    : drop pend once the buffered request is forwarded
//   d / q    : request payload in / held payload out
//   pend     : a buffered request is waiting
module dbus_req_buffer
    import dbus_arbiter_pkg::*;
(
    input  logic     clk,
    input  logic     rst,
    input  logic     load,
    input  logic     clear,
    input  bus_req_t d,
    output bus_req_t q,
    output logic     pend
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pend <= 1'b0;
            q    <= BUS_REQ_RST;
        end else if (load) begin
            pend <= 1'b1;
            q    <= d;
        end else if (clear) begin
            pend <= 1'b0;
        end
    end

endmodule

// File: rtl/dbus_arbiter.sv
// Two-master data-bus arbiter: core (m0) and debug SBA (m1) share downstream s.
// Pulses that lose arbitration or arrive while busy are buffered and replayed.
//   HI_PRIO_MASTER : tie winner in fixed-priority mode (0 core, 1 debug)
//   DBUS_ARB_RR_EN : when defined, ties go to the master that is not owner
//   clk, rst       : clock, async active-high reset
//   m0, m1         : upstream master ports (slave modport)
//   s              : downstream bus (master modport)
//   owner          : current / last granted master
//   busy           : downstream transaction in flight
//   arb_err        : pulse (cycle after the event) when an illegal request is dropped
module dbus_arbiter
    import dbus_arbiter_pkg::*;
#(
    parameter int unsigned HI_PRIO_MASTER = 1
) (
    input  logic          clk,
    input  logic          rst,
    master_bus_if.slave   m0,
    master_bus_if.slave   m1,
    master_bus_if.master  s,
    output logic          owner,
    output logic          busy,
    output logic          arb_err
);

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } arb_state_e;

    arb_state_e state;
    bus_req_t   live_req [2];
    bus_req_t   buf_req  [2];
    bus_req_t   win_req;
    bus_req_t   act_req;
    logic [1:0] live, viol, live_ok, cand, pend, load, clear;
    logic       tie_win, win, grant, resp_owner;

    logic unused_ok;
    assign unused_ok = &{1'b0, m0.breq, m1.breq};

    assign live_req[0] = '{addr: m0.addr, wdata: m0.wdata, ttype: m0.ttype, tsize: m0.tsize};
    assign live_req[1] = '{addr: m1.addr, wdata: m1.wdata, ttype: m1.ttype, tsize: m1.tsize};
    assign live        = {m1.bstart, m0.bstart};

    // A new event is illegal while that master already has a buffered or in-flight request.
    assign viol[0] = live[0] && (pend[0] || (state == BUSY && !owner));
    assign viol[1] = live[1] && (pend[1] || (state == BUSY &&  owner));
    assign live_ok = live & ~viol;
    assign cand    = live_ok | pend;

`ifdef DBUS_ARB_RR_EN
    assign tie_win = ~owner;
`else
    assign tie_win = 1'(HI_PRIO_MASTER);
`endif

    assign win   = (cand == 2'b11) ? tie_win : cand[1];
    assign grant = !rst && (state == IDLE) && (cand != 2'b00);

    // A master with a buffered request never also has a legal live one.
    assign win_req = win ? (pend[1] ? buf_req[1] : live_req[1])
                         : (pend[0] ? buf_req[0] : live_req[0]);

    // Capture any legal event that is not forwarded this cycle.
    assign load[0]  = live_ok[0] && !(grant && !win);
    assign load[1]  = live_ok[1] && !(grant &&  win);
    assign clear[0] = grant && !win && pend[0];
    assign clear[1] = grant &&  win && pend[1];

    dbus_req_buffer u_buf0 (
        .clk   (clk),
        .rst   (rst),
        .load  (load[0]),
        .clear (clear[0]),
        .d     (live_req[0]),
        .q     (buf_req[0]),
        .pend  (pend[0])
    );

    dbus_req_buffer u_buf1 (
        .clk   (clk),
        .rst   (rst),
        .load  (load[1]),
        .clear (clear[1]),
        .d     (live_req[1]),
        .q     (buf_req[1]),
        .pend  (pend[1])
    );

    // Downstream drive: the grant cycle is 0-latency from the winner, then held.
    always_comb begin
        s.bstart = grant;
        s.breq   = grant;
        {s.addr, s.wdata, s.ttype, s.tsize} = grant ? win_req : act_req;
    end

    // The registered owner lags the grant, so completions in the grant cycle use win.
    assign resp_owner = grant ? win : owner;

    always_comb begin
        m0.bdone = !rst && !resp_owner && s.bdone;
        m1.bdone = !rst &&  resp_owner && s.bdone;
        m0.rdata = (!rst && !resp_owner) ? s.rdata : '0;
        m1.rdata = (!rst &&  resp_owner) ? s.rdata : '0;
    end

    // State, owner, held request and error pulse.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            owner   <= 1'b0;
            act_req <= BUS_REQ_RST;
            arb_err <= 1'b0;
        end else begin
            arb_err <= |viol;
            if (grant) begin
                owner   <= win;
                act_req <= win_req;
            end
            case (state)
                IDLE:    if (grant && !s.bdone) state <= BUSY;
                BUSY:    if (s.bdone)           state <= IDLE;
                default:                        state <= IDLE;
            endcase
        end
    end

    assign busy = (state == BUSY);

endmodule

// File: tb/tb_dbus_arbiter.sv
// Self-checking bench for dbus_arbiter: directed scenarios plus randomized
// traffic checked against a transaction-level model of the arbitration rules.
module tb_dbus_arbiter;
    import dbus_arbiter_pkg::*;

    logic clk = 1'b0;
    logic rst;
    logic owner, busy, arb_err;
    int   errors = 0;
    int   checks = 0;

    master_bus_if m0_if ();
    master_bus_if m1_if ();
    master_bus_if s_if  ();

    dbus_arbiter #(.HI_PRIO_MASTER(1)) dut (
        .clk     (clk),
        .rst     (rst),
        .m0      (m0_if),
        .m1      (m1_if),
        .s       (s_if),
        .owner   (owner),
        .busy    (busy),
        .arb_err (arb_err)
    );

    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    task automatic clr_inputs();
        m0_if.bstart = 1'b0; m0_if.breq = 1'b0; m0_if.addr = '0; m0_if.wdata = '0;
        m0_if.ttype = READ; m0_if.tsize = WORD;
        m1_if.bstart = 1'b0; m1_if.breq = 1'b0; m1_if.addr = '0; m1_if.wdata = '0;
        m1_if.ttype = READ; m1_if.tsize = WORD;
        s_if.bdone = 1'b0; s_if.rdata = '0;
    endtask

    task automatic drive_m(input int i, input logic [31:0] a, input logic [31:0] d,
                           input ttype_e t, input tsize_e z);
        if (i == 0) begin
            m0_if.bstart = 1'b1; m0_if.breq = 1'b1; m0_if.addr = a; m0_if.wdata = d;
            m0_if.ttype = t; m0_if.tsize = z;
        end else begin
            m1_if.bstart = 1'b1; m1_if.breq = 1'b1; m1_if.addr = a; m1_if.wdata = d;
            m1_if.ttype = t; m1_if.tsize = z;
        end
    endtask

    task automatic drive_idle(input int i);
        if (i == 0) begin m0_if.bstart = 1'b0; m0_if.breq = 1'b0; end
        else        begin m1_if.bstart = 1'b0; m1_if.breq = 1'b0; end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        clr_inputs();
        repeat (2) @(negedge clk);
        #1;
        checks++; if ({s_if.bstart, s_if.breq} !== 2'b00) begin errors++; $display("FAIL rst_bstart: got %b want 00", {s_if.bstart, s_if.breq}); end
        checks++; if (s_if.addr !== 32'h0 || s_if.wdata !== 32'h0) begin errors++; $display("FAIL rst_fields: got %h/%h want 0/0", s_if.addr, s_if.wdata); end
        checks++; if (s_if.ttype !== READ || s_if.tsize !== WORD) begin errors++; $display("FAIL rst_type: got %0d/%0d want READ/WORD", s_if.ttype, s_if.tsize); end
        checks++; if ({m0_if.bdone, m1_if.bdone} !== 2'b00 || m0_if.rdata !== 32'h0 || m1_if.rdata !== 32'h0) begin errors++; $display("FAIL rst_resp: got %b %h %h want 00 0 0", {m0_if.bdone, m1_if.bdone}, m0_if.rdata, m1_if.rdata); end
        checks++; if ({owner, busy, arb_err} !== 3'b000) begin errors++; $display("FAIL rst_status: got %b want 000", {owner, busy, arb_err}); end
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_single_read();
        @(negedge clk);
        drive_m(0, 32'h100, 32'h0, READ, WORD);
        #1;
        checks++; if ({s_if.bstart, s_if.breq} !== 2'b11) begin errors++; $display("FAIL single_bstart: got %b want 11", {s_if.bstart, s_if.breq}); end
        checks++; if (s_if.addr !== 32'h100) begin errors++; $display("FAIL single_addr: got %h want 100", s_if.addr); end
        @(negedge clk);
        drive_idle(0);
        #1;
        checks++; if ({busy, owner, s_if.bstart} !== 3'b100) begin errors++; $display("FAIL single_busy: got %b want 100", {busy, owner, s_if.bstart}); end
        checks++; if (s_if.addr !== 32'h100) begin errors++; $display("FAIL single_hold: got %h want 100", s_if.addr); end
        @(negedge clk);
        s_if.bdone = 1'b1; s_if.rdata = 32'hCAFE0100;
        #1;
        checks++; if (m0_if.bdone !== 1'b1 || m0_if.rdata !== 32'hCAFE0100) begin errors++; $display("FAIL single_done: got %b %h want 1 cafe0100", m0_if.bdone, m0_if.rdata); end
        checks++; if (m1_if.bdone !== 1'b0 || m1_if.rdata !== 32'h0) begin errors++; $display("FAIL single_other: got %b %h want 0 0", m1_if.bdone, m1_if.rdata); end
        @(negedge clk);
        s_if.bdone = 1'b0; s_if.rdata = '0;
        #1;
        checks++; if ({busy, owner} !== 2'b00) begin errors++; $display("FAIL single_end: got %b want 00", {busy, owner}); end
    endtask

`ifndef DBUS_ARB_RR_EN
    task automatic test_fixed_prio();
        @(negedge clk);
        drive_m(0, 32'h200, 32'h0, READ, WORD);
        drive_m(1, 32'h300, 32'hDEADBEEF, WRITE, WORD);
        #1;
        checks++; if (s_if.bstart !== 1'b1 || s_if.addr !== 32'h300 || s_if.wdata !== 32'hDEADBEEF || s_if.ttype !== WRITE) begin errors++; $display("FAIL prio_first: got %b %h %h want 1 300 deadbeef", s_if.bstart, s_if.addr, s_if.wdata); end
        @(negedge clk);
        drive_idle(0); drive_idle(1);
        #1;
        checks++; if ({owner, busy, s_if.bstart} !== 3'b110) begin errors++; $display("FAIL prio_busy: got %b want 110", {owner, busy, s_if.bstart}); end
        @(negedge clk);
        s_if.bdone = 1'b1; s_if.rdata = 32'h33;
        #1;
        checks++; if ({m1_if.bdone, m0_if.bdone} !== 2'b10 || m1_if.rdata !== 32'h33 || m0_if.rdata !== 32'h0) begin errors++; $display("FAIL prio_done1: got %b %h %h want 10 33 0", {m1_if.bdone, m0_if.bdone}, m1_if.rdata, m0_if.rdata); end
        @(negedge clk);
        s_if.bdone = 1'b0; s_if.rdata = '0;
        #1;
        checks++; if (s_if.bstart !== 1'b1 || s_if.addr !== 32'h200 || s_if.ttype !== READ) begin errors++; $display("FAIL prio_replay: got %b %h want 1 200", s_if.bstart, s_if.addr); end
        @(negedge clk);
        s_if.bdone = 1'b1;
        #1;
        checks++; if ({m1_if.bdone, m0_if.bdone} !== 2'b01) begin errors++; $display("FAIL prio_done0: got %b want 01", {m1_if.bdone, m0_if.bdone}); end
        @(negedge clk);
        s_if.bdone = 1'b0;
        #1;
        checks++; if ({owner, busy} !== 2'b00) begin errors++; $display("FAIL prio_end: got %b want 00", {owner, busy}); end
    endtask
`else
    task automatic test_round_robin();
        @(negedge clk);
        drive_m(1, 32'h310, 32'h0, READ, WORD); s_if.bdone = 1'b1;
        @(negedge clk);
        drive_idle(1);
        checks++; if ({owner, busy} !== 2'b10) begin errors++; $display("FAIL rr_own1: got %b want 10", {owner, busy}); end
        drive_m(0, 32'h210, 32'h0, READ, WORD); drive_m(1, 32'h320, 32'h0, READ, WORD);
        #1;
        checks++; if (s_if.bstart !== 1'b1 || s_if.addr !== 32'h210) begin errors++; $display("FAIL rr_m0_wins: got %b %h want 1 210", s_if.bstart, s_if.addr); end
        @(negedge clk);
        drive_idle(0); drive_idle(1);
        #1;
        checks++; if (s_if.bstart !== 1'b1 || s_if.addr !== 32'h320) begin errors++; $display("FAIL rr_replay1: got %b %h want 1 320", s_if.bstart, s_if.addr); end
        @(negedge clk);
        drive_m(0, 32'h220, 32'h0, READ, WORD);
        @(negedge clk);
        drive_idle(0);
        checks++; if (owner !== 1'b0) begin errors++; $display("FAIL rr_own0: got %b want 0", owner); end
        drive_m(0, 32'h230, 32'h0, READ, WORD); drive_m(1, 32'h330, 32'h0, READ, WORD);
        #1;
        checks++; if (s_if.bstart !== 1'b1 || s_if.addr !== 32'h330) begin errors++; $display("FAIL rr_m1_wins: got %b %h want 1 330", s_if.bstart, s_if.addr); end
        @(negedge clk);
        drive_idle(0); drive_idle(1);
        #1;
        checks++; if (s_if.bstart !== 1'b1 || s_if.addr !== 32'h230) begin errors++; $display("FAIL rr_replay0: got %b %h want 1 230", s_if.bstart, s_if.addr); end
        @(negedge clk);
        s_if.bdone = 1'b0;
        #1;
        checks++; if ({owner, busy, s_if.bstart} !== 3'b000) begin errors++; $display("FAIL rr_end: got %b want 000", {owner, busy, s_if.bstart}); end
    endtask
`endif

    task automatic test_violation();
        @(negedge clk);
        drive_m(0, 32'h400, 32'h0, READ, WORD);
        #1;
        checks++; if (s_if.bstart !== 1'b1) begin errors++; $display("FAIL viol_grant0: got %b want 1", s_if.bstart); end
        @(negedge clk);
        drive_idle(0); drive_m(1, 32'h500, 32'hAAAA5555, WRITE, HALF);
        #1;
        checks++; if (s_if.bstart !== 1'b0 || s_if.addr !== 32'h400) begin errors++; $display("FAIL viol_hold: got %b %h want 0 400", s_if.bstart, s_if.addr); end
        @(negedge clk);
        drive_m(1, 32'h600, 32'h0, READ, BYTE);
        #1;
        checks++; if (arb_err !== 1'b0) begin errors++; $display("FAIL viol_first_ok: got %b want 0", arb_err); end
        @(negedge clk);
        drive_idle(1); drive_m(0, 32'h700, 32'h0, READ, WORD);
        #1;
        checks++; if (arb_err !== 1'b1) begin errors++; $display("FAIL viol_pend_err: got %b want 1", arb_err); end
        @(negedge clk);
        drive_idle(0);
        #1;
        checks++; if (arb_err !== 1'b1) begin errors++; $display("FAIL viol_owner_err: got %b want 1", arb_err); end
        @(negedge clk);
        s_if.bdone = 1'b1;
        #1;
        checks++; if (m0_if.bdone !== 1'b1 || arb_err !== 1'b0) begin errors++; $display("FAIL viol_done0: got %b %b want 1 0", m0_if.bdone, arb_err); end
        @(negedge clk);
        s_if.bdone = 1'b0;
        #1;
        checks++; if (s_if.bstart !== 1'b1 || s_if.addr !== 32'h500 || s_if.wdata !== 32'hAAAA5555 || s_if.ttype !== WRITE || s_if.tsize !== HALF) begin errors++; $display("FAIL viol_replay: got %b %h %h %0d %0d want 1 500 aaaa5555 WRITE HALF", s_if.bstart, s_if.addr, s_if.wdata, s_if.ttype, s_if.tsize); end
        s_if.bdone = 1'b1;
        #1;
        checks++; if ({m1_if.bdone, m0_if.bdone} !== 2'b10) begin errors++; $display("FAIL viol_same_done: got %b want 10", {m1_if.bdone, m0_if.bdone}); end
        @(negedge clk);
        s_if.bdone = 1'b0;
        #1;
        checks++; if ({busy, owner, s_if.bstart} !== 3'b010) begin errors++; $display("FAIL viol_end: got %b want 010", {busy, owner, s_if.bstart}); end
        @(negedge clk);
        #1;
        checks++; if (s_if.bstart !== 1'b0) begin errors++; $display("FAIL viol_dropped: got %b want 0", s_if.bstart); end
    endtask

    task automatic test_bdone_same_cycle();
        @(negedge clk);
        drive_m(1, 32'h800, 32'h0, READ, WORD);
        @(negedge clk);
        drive_idle(1); drive_m(0, 32'h900, 32'h99, WRITE, WORD);
        #1;
        checks++; if (s_if.bstart !== 1'b0) begin errors++; $display("FAIL same_busy: got %b want 0", s_if.bstart); end
        @(negedge clk);
        drive_idle(0); s_if.bdone = 1'b1;
        #1;
        checks++; if (m1_if.bdone !== 1'b1) begin errors++; $display("FAIL same_done1: got %b want 1", m1_if.bdone); end
        @(negedge clk);
        s_if.bdone = 1'b0;
        #1;
        checks++; if (s_if.bstart !== 1'b1 || s_if.addr !== 32'h900 || s_if.wdata !== 32'h99) begin errors++; $display("FAIL same_replay: got %b %h %h want 1 900 99", s_if.bstart, s_if.addr, s_if.wdata); end
        s_if.bdone = 1'b1;
        #1;
        checks++; if ({m1_if.bdone, m0_if.bdone} !== 2'b01) begin errors++; $display("FAIL same_done0: got %b want 01", {m1_if.bdone, m0_if.bdone}); end
        @(negedge clk);
        s_if.bdone = 1'b0; drive_m(1, 32'hA00, 32'h0, READ, WORD);
        #1;
        checks++; if ({busy, owner} !== 2'b00) begin errors++; $display("FAIL same_idle: got %b want 00", {busy, owner}); end
        checks++; if (s_if.bstart !== 1'b1 || s_if.addr !== 32'hA00) begin errors++; $display("FAIL same_next: got %b %h want 1 a00", s_if.bstart, s_if.addr); end
        s_if.bdone = 1'b1;
        @(negedge clk);
        drive_idle(1); s_if.bdone = 1'b0;
        #1;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL same_end: got %b want 0", busy); end
    endtask

    task automatic test_reset_mid_busy();
        @(negedge clk);
        drive_m(1, 32'hB00, 32'h1234, WRITE, WORD);
        @(negedge clk);
        drive_idle(1); drive_m(0, 32'hC00, 32'h0, READ, WORD);
        @(negedge clk);
        drive_idle(0);
        #1;
        checks++; if ({owner, busy} !== 2'b11) begin errors++; $display("FAIL rstb_pre: got %b want 11", {owner, busy}); end
        rst = 1'b1; s_if.rdata = 32'h5555;
        #1;
        checks++; if ({s_if.bstart, s_if.breq} !== 2'b00 || s_if.addr !== 32'h0 || s_if.wdata !== 32'h0 || s_if.ttype !== READ || s_if.tsize !== WORD) begin errors++; $display("FAIL rstb_bus: got %b %h %h want 00 0 0", {s_if.bstart, s_if.breq}, s_if.addr, s_if.wdata); end
        checks++; if ({owner, busy, arb_err} !== 3'b000 || m0_if.rdata !== 32'h0 || m1_if.rdata !== 32'h0) begin errors++; $display("FAIL rstb_status: got %b %h %h want 000 0 0", {owner, busy, arb_err}, m0_if.rdata, m1_if.rdata); end
        @(negedge clk);
        rst = 1'b0; s_if.rdata = '0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            #1;
            checks++; if (s_if.bstart !== 1'b0) begin errors++; $display("FAIL rstb_no_replay: cycle %0d got %b want 0", k, s_if.bstart); end
        end
    endtask

    task automatic test_random();
        bus_req_t   req [2];
        bus_req_t   cur;
        logic [1:0] outst, issued;
        int         age [2];
        logic       sl_busy;
        int         sl_m, sl_lat, last_owner, g, exp_w;
        logic [31:0] rd;
        rst = 1'b1; clr_inputs();
        @(negedge clk);
        rst = 1'b0;
        outst = '0; issued = '0; sl_busy = 1'b0; sl_m = 0; sl_lat = 0; last_owner = 0;
        age[0] = 0; age[1] = 0;
        for (int cyc = 0; cyc < 400; cyc++) begin
            @(negedge clk);
            checks++; if (arb_err !== 1'b0) begin errors++; $display("FAIL rnd_err: cycle %0d got %b want 0", cyc, arb_err); end
            s_if.bdone = 1'b0; s_if.rdata = '0;
            for (int i = 0; i < 2; i++) begin
                drive_idle(i);
                if (!outst[i] && cyc < 360 && $urandom_range(2) == 0) begin
                    req[i].addr  = {31'($urandom()), 1'(i)};
                    req[i].wdata = $urandom();
                    req[i].ttype = ttype_e'(1'($urandom_range(1)));
                    req[i].tsize = tsize_e'(2'($urandom_range(2)));
                    drive_m(i, req[i].addr, req[i].wdata, req[i].ttype, req[i].tsize);
                    outst[i] = 1'b1; issued[i] = 1'b0; age[i] = 0;
                end
            end
            #1;
            if (!sl_busy && (outst & ~issued) != 2'b00) begin
                checks++; if (s_if.bstart !== 1'b1) begin errors++; $display("FAIL rnd_stall: cycle %0d got %b want 1", cyc, s_if.bstart); end
            end
            if (s_if.bstart === 1'b1) begin
                g = int'(s_if.addr[0]);
                cur = '{addr: s_if.addr, wdata: s_if.wdata, ttype: s_if.ttype, tsize: s_if.tsize};
                checks++; if (sl_busy) begin errors++; $display("FAIL rnd_overlap: cycle %0d got bstart want none", cyc); end
                checks++; if (!(outst[g] && !issued[g]) || cur !== req[g]) begin errors++; $display("FAIL rnd_grant: cycle %0d got %h want %h", cyc, cur, req[g]); end
                if (outst == 2'b11 && issued == 2'b00) begin
`ifdef DBUS_ARB_RR_EN
                    exp_w = 1 - last_owner;
`else
                    exp_w = 1;
`endif
                    checks++; if (g != exp_w) begin errors++; $display("FAIL rnd_tie: cycle %0d got %0d want %0d", cyc, g, exp_w); end
                end
                issued[g] = 1'b1; sl_busy = 1'b1; sl_m = g; sl_lat = $urandom_range(3); last_owner = g;
            end
            if (sl_busy) begin
                if (sl_lat == 0) begin
                    s_if.bdone = 1'b1; s_if.rdata = ~req[sl_m].addr;
                    #1;
                    rd = (sl_m == 1) ? m1_if.rdata : m0_if.rdata;
                    checks++; if ({m1_if.bdone, m0_if.bdone} !== ((sl_m == 1) ? 2'b10 : 2'b01) || rd !== ~req[sl_m].addr) begin errors++; $display("FAIL rnd_resp: cycle %0d got %b %h want m%0d %h", cyc, {m1_if.bdone, m0_if.bdone}, rd, sl_m, ~req[sl_m].addr); end
                    outst[sl_m] = 1'b0; issued[sl_m] = 1'b0; sl_busy = 1'b0;
                end else begin
                    sl_lat--;
                end
            end
            for (int i = 0; i < 2; i++) begin
                if (outst[i]) begin
                    age[i]++;
                    if (age[i] > 40) begin
                        checks++; errors++;
                        $display("FAIL rnd_timeout: master %0d got age %0d want <=40", i, age[i]);
                        outst[i] = 1'b0;
                    end
                end
            end
        end
        clr_inputs();
    endtask

    initial begin
        rst = 1'b1;
        clr_inputs();
        test_reset();
        test_single_read();
`ifndef DBUS_ARB_RR_EN
        test_fixed_prio();
`else
        test_round_robin();
`endif
        test_violation();
        test_bdone_same_cycle();
        test_reset_mid_busy();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
